// File: rtl/cnn_stream_pkg.sv
// Shared types and sizing helpers for the CNN frame streamer.
package cnn_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_GAP,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int DEF_IMG_W     = 28;
  localparam int DEF_IMG_H     = 28;
  localparam int PIX_PER_FRAME = DEF_IMG_W * DEF_IMG_H;

  function automatic int pix_per_frame(input int img_w, input int img_h);
    return img_w * img_h;
  endfunction

  function automatic int addr_width(input int pix);
    return (pix > 1) ? $clog2(pix) : 1;
  endfunction

endpackage

// File: rtl/cnn_frame_streamer_if.sv
// Host/CNN-facing signal bundle of the frame streamer; master = host side, slave = streamer.
interface cnn_frame_streamer_if
  import cnn_stream_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = addr_width(PIX_PER_FRAME),
  parameter int GAP_W  = 16
) ();

  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [PIX_W-1:0]  load_data;
  logic              start;
  logic [7:0]        num_frames;
  logic [GAP_W-1:0]  gap_cycles;
  logic [PIX_W-1:0]  pixel_out;
  logic              pixel_valid;
  logic              result_valid;
  logic [15:0]       exp_results;
  logic              busy;
  logic              done;
  logic              timeout_err;
  logic [7:0]        frames_sent;
  logic [15:0]       result_count;

  modport master (
    output load_we, load_addr, load_data, start, num_frames, gap_cycles,
           result_valid, exp_results,
    input  pixel_out, pixel_valid, busy, done, timeout_err, frames_sent, result_count
  );

  modport slave (
    input  load_we, load_addr, load_data, start, num_frames, gap_cycles,
           result_valid, exp_results,
    output pixel_out, pixel_valid, busy, done, timeout_err, frames_sent, result_count
  );

endinterface

// File: rtl/cnn_image_ram.sv
// Single-frame image store: one write port, one synchronous read port (1-cycle latency).
module cnn_image_ram #(
  parameter int PIX_W  = 8,
  parameter int DEPTH  = 784,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cnn_frame_streamer.sv
// Replays a stored image as a raster pixel stream to a CNN and counts its results.
// Optional drain watchdog enabled by defining CNN_STREAM_TIMEOUT_EN.
module cnn_frame_streamer
  import cnn_stream_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int GAP_W     = 16,
  parameter int TO_CYCLES = 20000
) (
  input logic                 clock,
  input logic                 reset_n,
  cnn_frame_streamer_if.slave bus
);

  localparam int FRAME_PIX = pix_per_frame(IMG_W, IMG_H);
  localparam int ADDR_W    = addr_width(FRAME_PIX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        nf_q, issued;
  logic [GAP_W-1:0]  gap_q, gap_cnt;
  logic              vld_p0, last_p0, vld_p1;
  logic [PIX_W-1:0]  ram_q, pix_p1;
  logic              busy_r, done_r;
  logic [7:0]        frames_r;
  logic [15:0]       results_r;
  logic              drain_ok;

  // A run only completes once the final pixel has actually left the output register.
  assign drain_ok = (frames_r == nf_q) && (results_r >= bus.exp_results);

`ifdef CNN_STREAM_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES + 1);
  logic [TO_W-1:0] drain_cnt;
  logic            timeout_r;
`endif

  cnn_image_ram #(.PIX_W(PIX_W), .DEPTH(FRAME_PIX), .ADDR_W(ADDR_W)) u_ram (
    .clock   (clock),
    .wr_en   (bus.load_we && (state == ST_IDLE)),
    .wr_addr (bus.load_addr),
    .wr_data (bus.load_data),
    .rd_addr (addr),
    .rd_data (ram_q)
  );

  // Stage p0: address issue and run control; read data lands in ram_q one cycle later
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      nf_q      <= '0;
      issued    <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      vld_p0    <= 1'b0;
      last_p0   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      frames_r  <= '0;
      results_r <= '0;
`ifdef CNN_STREAM_TIMEOUT_EN
      drain_cnt <= '0;
      timeout_r <= 1'b0;
`endif
    end else begin
      done_r  <= 1'b0;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      if (vld_p0 && last_p0) frames_r <= frames_r + 8'd1;
      if (bus.result_valid && busy_r) results_r <= sat_inc(results_r);
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.num_frames != 8'd0) begin
              nf_q      <= bus.num_frames;
              gap_q     <= bus.gap_cycles;
              frames_r  <= '0;
              results_r <= '0;
              issued    <= '0;
              addr      <= '0;
              busy_r    <= 1'b1;
              state     <= ST_STREAM;
`ifdef CNN_STREAM_TIMEOUT_EN
              timeout_r <= 1'b0;
`endif
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          vld_p0  <= 1'b1;
          last_p0 <= (addr == LAST_ADDR);
          if (addr == LAST_ADDR) begin
            addr   <= '0;
            issued <= issued + 8'd1;
            if (issued + 8'd1 == nf_q) begin
              state <= ST_DRAIN;
`ifdef CNN_STREAM_TIMEOUT_EN
              drain_cnt <= '0;
`endif
            end else if (gap_q != '0) begin
              gap_cnt <= GAP_W'(1);
              state   <= ST_GAP;
            end
          end else begin
            addr <= addr + ADDR_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == gap_q) state <= ST_STREAM;
          else gap_cnt <= gap_cnt + GAP_W'(1);
        end
        ST_DRAIN: begin
          if (drain_ok) begin
            state  <= ST_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
`ifdef CNN_STREAM_TIMEOUT_EN
          else if (drain_cnt == TO_W'(TO_CYCLES - 1)) begin
            state     <= ST_DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            timeout_r <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + TO_W'(1);
          end
`endif
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p1: output register; blanks the pixel bus whenever no pixel is valid
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
      pix_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      pix_p1 <= vld_p0 ? ram_q : '0;
    end
  end

  assign bus.pixel_out    = pix_p1;
  assign bus.pixel_valid  = vld_p1;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.frames_sent  = frames_r;
  assign bus.result_count = results_r;
`ifdef CNN_STREAM_TIMEOUT_EN
  assign bus.timeout_err  = timeout_r;
`else
  assign bus.timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_frame_streamer.sv
// Randomized self-checking bench for cnn_frame_streamer against a frame/gap stream model.
module tb_cnn_frame_streamer;
  import cnn_stream_pkg::*;

  localparam int PIX_W     = 8;
  localparam int IMG_W     = 28;
  localparam int IMG_H     = 28;
  localparam int GAP_W     = 16;
  localparam int TO_CYCLES = 100;
  localparam int NPIX      = IMG_W * IMG_H;
  localparam int AW        = addr_width(NPIX);

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  cnn_frame_streamer_if #(.PIX_W(PIX_W), .ADDR_W(AW), .GAP_W(GAP_W)) bus ();

  cnn_frame_streamer #(
    .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .GAP_W(GAP_W), .TO_CYCLES(TO_CYCLES)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int model_mem [NPIX];
  int cap_v [$];
  int cap_p [$];
  int first_v, last_v, done_cnt, done_idx;

  task automatic load_mem(input bit random_fill);
    for (int i = 0; i < NPIX; i++) begin
      int d;
      d = random_fill ? int'($urandom_range(0, 255)) : (i % 256);
      model_mem[i] = d;
      @(negedge clock);
      bus.load_we   = 1'b1;
      bus.load_addr = AW'(i);
      bus.load_data = PIX_W'(d);
    end
    @(negedge clock);
    bus.load_we = 1'b0;
  endtask

  // Starts a run and records every cycle from the edge that samples start.
  task automatic run_capture(input int nf, input int gap, input int exp_res,
                             input int n_pulses, input int budget, input int poke_at);
    int pulses_left;
    pulses_left = n_pulses;
    cap_v.delete();
    cap_p.delete();
    first_v = -1; last_v = -1; done_cnt = 0; done_idx = -1;
    @(negedge clock);
    bus.num_frames  = 8'(nf);
    bus.gap_cycles  = GAP_W'(gap);
    bus.exp_results = 16'(exp_res);
    bus.start       = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    for (int s = 1; s <= budget; s++) begin
      cap_v.push_back(int'(bus.pixel_valid));
      cap_p.push_back(int'(bus.pixel_out));
      if (bus.pixel_valid) begin
        if (first_v < 0) first_v = s;
        last_v = s;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = s;
      end
      if (done_idx >= 0 && s >= done_idx + 3) break;
      bus.result_valid = (pulses_left > 0) && (bus.frames_sent == 8'(nf)) && bus.busy;
      if (bus.result_valid) pulses_left--;
      bus.start   = (s == poke_at);
      bus.load_we = (s == poke_at);
      if (s == poke_at) begin
        bus.num_frames = 8'd5;
        bus.load_addr  = AW'(5);
        bus.load_data  = PIX_W'(~model_mem[5]);
      end
      @(negedge clock);
    end
    bus.result_valid = 1'b0;
    bus.start        = 1'b0;
    bus.load_we      = 1'b0;
  endtask

  // Reference: nf frames of mem[0..NPIX-1], gap idle zero cycles between them, then idle.
  function automatic int stream_errs(input int nf, input int gap);
    int len, errs, period, r, ev, ep, idx;
    if (first_v < 1) return 1;
    len = nf * NPIX + (nf - 1) * gap;
    period = NPIX + gap;
    errs = 0;
    for (int k = 0; k <= len; k++) begin
      idx = first_v - 1 + k;
      if (idx >= cap_v.size()) return errs + 1;
      r = k % period;
      if (k == len)       begin ev = 0; ep = 0; end
      else if (r < NPIX)  begin ev = 1; ep = model_mem[r]; end
      else                begin ev = 0; ep = 0; end
      if (cap_v[idx] != ev || cap_p[idx] != ep) errs++;
    end
    return errs;
  endfunction

  task automatic test_reset();
    bus.load_we = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    bus.start = 1'b0; bus.num_frames = '0; bus.gap_cycles = '0;
    bus.result_valid = 1'b0; bus.exp_results = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({bus.pixel_valid, bus.busy, bus.done, bus.timeout_err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b want=0000",
                         {bus.pixel_valid, bus.busy, bus.done, bus.timeout_err});
    end
    n_checks++;
    if (bus.frames_sent !== 8'd0 || bus.pixel_out !== '0) begin
      n_fail++; $display("FAIL reset_frames got=%0d/%0d want=0/0", bus.frames_sent, bus.pixel_out);
    end
    n_checks++;
    if (bus.result_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_results got=%0d want=0", bus.result_count);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single_frame();
    int e;
    load_mem(1'b0);
    run_capture(1, 0, 0, 0, NPIX + 100, -1);
    n_checks++;
    if (first_v !== 3) begin n_fail++; $display("FAIL first_latency got=%0d want=3", first_v); end
    e = stream_errs(1, 0);
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL single_stream got=%0d bad cycles want=0", e); end
    n_checks++;
    if (last_v - first_v + 1 !== NPIX) begin
      n_fail++; $display("FAIL single_span got=%0d want=%0d", last_v - first_v + 1, NPIX);
    end
    n_checks++;
    if (bus.frames_sent !== 8'd1 || done_cnt !== 1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL single_status got=frames %0d done %0d busy %b want=1 1 0",
                         bus.frames_sent, done_cnt, bus.busy);
    end
  endtask

  task automatic test_zero_frames();
    @(negedge clock);
    bus.num_frames = 8'd0;
    bus.start      = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_done got=done %b busy %b want=1 0", bus.done, bus.busy);
    end
    @(negedge clock);
    n_checks++;
    if (bus.done !== 1'b0 || bus.frames_sent !== 8'd1) begin
      n_fail++; $display("FAIL zero_after got=done %b frames %0d want=0 1", bus.done, bus.frames_sent);
    end
  endtask

  task automatic test_gap();
    int e;
    load_mem(1'b1);
    run_capture(2, 3, 0, 0, 2 * NPIX + 100, -1);
    e = stream_errs(2, 3);
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL gap_stream got=%0d bad cycles want=0", e); end
    n_checks++;
    if (last_v - first_v + 1 !== 1571) begin
      n_fail++; $display("FAIL gap_span got=%0d want=1571", last_v - first_v + 1);
    end
    n_checks++;
    if (bus.frames_sent !== 8'd2) begin
      n_fail++; $display("FAIL gap_frames got=%0d want=2", bus.frames_sent);
    end
  endtask

  task automatic test_back_to_back();
    int nf, e;
    nf = int'($urandom_range(2, 3));
    run_capture(nf, 0, 0, 0, nf * NPIX + 100, -1);
    e = stream_errs(nf, 0);
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL b2b_stream got=%0d bad cycles want=0", e); end
    n_checks++;
    if (last_v - first_v + 1 !== nf * NPIX || bus.frames_sent !== 8'(nf)) begin
      n_fail++; $display("FAIL b2b_span got=%0d frames %0d want=%0d frames %0d",
                         last_v - first_v + 1, bus.frames_sent, nf * NPIX, nf);
    end
  endtask

  task automatic test_timeout();
    run_capture(1, 0, 5, 0, NPIX + TO_CYCLES + 50, -1);
`ifdef CNN_STREAM_TIMEOUT_EN
    n_checks++;
    if (bus.timeout_err !== 1'b1 || done_cnt !== 1) begin
      n_fail++; $display("FAIL timeout_flag got=err %b done %0d want=1 1", bus.timeout_err, done_cnt);
    end
    // The last pixel leaves the output register one cycle into DRAIN.
    n_checks++;
    if (done_idx - last_v !== TO_CYCLES - 1) begin
      n_fail++; $display("FAIL timeout_len got=%0d want=%0d", done_idx - last_v, TO_CYCLES - 1);
    end
`else
    n_checks++;
    if (bus.busy !== 1'b1 || done_cnt !== 0 || bus.timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL drain_wait got=busy %b done %0d err %b want=1 0 0",
                         bus.busy, done_cnt, bus.timeout_err);
    end
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
`endif
  endtask

  task automatic test_results();
    run_capture(1, 0, 10, 10, NPIX + 200, -1);
    n_checks++;
    if (done_cnt !== 1 || bus.result_count !== 16'd10 || bus.timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL results_done got=done %0d count %0d err %b want=1 10 0",
                         done_cnt, bus.result_count, bus.timeout_err);
    end
    repeat (3) begin
      bus.result_valid = 1'b1;
      @(negedge clock);
    end
    bus.result_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (bus.result_count !== 16'd10 || bus.frames_sent !== 8'd1) begin
      n_fail++; $display("FAIL idle_hold got=count %0d frames %0d want=10 1",
                         bus.result_count, bus.frames_sent);
    end
  endtask

  task automatic test_reset_mid_frame();
    int seen, e;
    seen = 0;
    @(negedge clock);
    bus.num_frames = 8'd1; bus.gap_cycles = '0; bus.exp_results = '0; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    for (int s = 0; s < NPIX && seen < 400; s++) begin
      if (bus.pixel_valid) seen++;
      if (seen < 400) @(negedge clock);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.pixel_valid !== 1'b0 || bus.busy !== 1'b0 || bus.frames_sent !== 8'd0 || seen !== 400) begin
      n_fail++; $display("FAIL midreset got=valid %b busy %b frames %0d seen %0d want=0 0 0 400",
                         bus.pixel_valid, bus.busy, bus.frames_sent, seen);
    end
    @(negedge clock);
    reset_n = 1'b1;
    run_capture(1, 0, 0, 0, NPIX + 100, -1);
    e = stream_errs(1, 0);
    n_checks++;
    if (e !== 0 || first_v !== 3 || bus.frames_sent !== 8'd1) begin
      n_fail++; $display("FAIL restart_stream got=%0d bad first %0d frames %0d want=0 3 1",
                         e, first_v, bus.frames_sent);
    end
  endtask

  task automatic test_busy_ignore();
    int e;
    run_capture(1, 0, 0, 0, NPIX + 100, 100);
    n_checks++;
    if (bus.frames_sent !== 8'd1 || done_cnt !== 1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_start got=frames %0d done %0d busy %b want=1 1 0",
                         bus.frames_sent, done_cnt, bus.busy);
    end
    run_capture(1, 0, 0, 0, NPIX + 100, -1);
    e = stream_errs(1, 0);
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL busy_write got=%0d bad cycles want=0", e); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_zero_frames();
    test_gap();
    test_back_to_back();
    test_timeout();
    test_results();
    test_reset_mid_frame();
    test_busy_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_frame_streamer.md
CNN_FRAME_STREAMER -- requirements
Module: cnn_frame_streamer

Interface
REQ-001 SHALL have parameter PIX_W, default 8: pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 28: image width in pixels.
REQ-003 SHALL have parameter IMG_H, default 28: image height in pixels.
REQ-004 SHALL have parameter GAP_W, default 16: width of the inter-frame gap count.
REQ-005 SHALL have parameter TO_CYCLES, default 20000: drain watchdog limit in cycles.
REQ-006 SHALL have port clock, input, 1: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have ports load_we (input, 1), load_addr (input, ADDR_W = clog2(IMG_W*IMG_H)) and load_data (input, PIX_W): image memory write port.
REQ-009 SHALL have ports start (input, 1), num_frames (input, 8) and gap_cycles (input, GAP_W): run request and run settings.
REQ-010 SHALL have ports pixel_out (output, PIX_W) and pixel_valid (output, 1): the pixel stream sent to the CNN.
REQ-011 SHALL have ports result_valid (input, 1) and exp_results (input, 16): CNN output strobe and expected total result count.
REQ-012 SHALL have outputs busy (1), done (1), timeout_err (1), frames_sent (8) and result_count (16): status.

Function
REQ-013 SHALL implement states IDLE, STREAM, GAP, DRAIN and DONE.
REQ-014 In IDLE, start with num_frames != 0 SHALL latch num_frames and gap_cycles, clear frames_sent, result_count and timeout_err, and go to STREAM.
REQ-015 In IDLE, start with num_frames == 0 SHALL pulse done for 1 cycle and stay in IDLE.
REQ-016 start SHALL be ignored in every state other than IDLE.
REQ-017 The first pixel_valid SHALL appear 2 cycles after the edge that samples start; this latency comes from the synchronous RAM read plus the output register.
REQ-018 In STREAM, pixel_valid SHALL be 1 on every cycle, and pixel_out SHALL be mem[0..IMG_W*IMG_H-1] in raster order with no holes.
REQ-019 Each time the last pixel of a frame is output, frames_sent SHALL increment.
REQ-020 After the last pixel of a frame that is not the last frame:
- gap_cycles > 0: go to GAP, with pixel_valid = 0 and pixel_out = 0 for exactly gap_cycles cycles, then resume at address 0.
- gap_cycles == 0: the next frame follows back-to-back at address 0.
REQ-021 After the last pixel of the last frame, SHALL go to DRAIN.
REQ-022 result_count SHALL increment on every result_valid sampled in STREAM, GAP or DRAIN, SHALL saturate at 16'hFFFF, and SHALL ignore result_valid in IDLE.
REQ-023 In DRAIN, when result_count >= exp_results, SHALL go to DONE; this check also applies on the first DRAIN cycle.
REQ-024 DONE SHALL last 1 cycle with done = 1, then return to IDLE; busy SHALL be 1 in STREAM, GAP and DRAIN.
REQ-025 load_we SHALL write the memory only in IDLE; writes in any other state SHALL be dropped.
REQ-026 frames_sent, result_count and timeout_err SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-027 reset_n low SHALL, without waiting for a clock edge, force state IDLE, all outputs 0, and all counters and the address to 0.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 Reset in the middle of a frame SHALL drop pixel_valid immediately; the next run SHALL start at address 0.

Configuration
REQ-030 When macro CNN_STREAM_TIMEOUT_EN is defined, a DRAIN cycle counter SHALL run; on the TO_CYCLES-th DRAIN cycle without completion it SHALL set timeout_err (held until the next accepted start) and go to DONE.
REQ-031 When CNN_STREAM_TIMEOUT_EN is undefined, DRAIN SHALL wait forever and timeout_err SHALL be tied to 0.

Structure
REQ-032 Package cnn_stream_pkg SHALL hold the state enum, the ADDR_W computation, and the constant PIX_PER_FRAME = IMG_W*IMG_H.
REQ-033 Sub-module cnn_image_ram SHALL hold the storage: one write port and one synchronous read port with 1-cycle read latency, PIX_W x PIX_PER_FRAME.

Verification
REQ-034 Load mem[i] = i mod 256, then start with num_frames = 1 and gap 0: 784 consecutive valid cycles, pixel_out = 0,1,...,255,0,..., frames_sent = 1.
REQ-035 num_frames = 2, gap_cycles = 3: 784 valid, then 3 invalid, then 784 valid; 1571 cycles from first to last valid pixel; frames_sent = 2.
REQ-036 exp_results = 10, drive 10 result_valid pulses during DRAIN: done pulses once, result_count = 10, timeout_err = 0.
REQ-037 With the macro defined, TO_CYCLES = 100 and no result_valid: timeout_err = 1 and done pulses after 100 DRAIN cycles; without the macro, busy stays 1.
REQ-038 Assert reset_n low at pixel 400, then start again: pixel_valid is 0 at once, and the new stream begins at mem[0] with frames_sent = 0.
REQ-039 start while busy, and load_we while busy: both ignored, and the memory readback is unchanged.
